// File: rtl/d_mem_arb_pkg.sv
// d_mem_arb_pkg: shared types for the data-memory arbiter slice (package ss_rvc_pkg).
package ss_rvc_pkg;
   typedef enum logic {RD = 1'b0, WR = 1'b1} t_opcode;
   typedef enum logic [1:0] {NONE, CORE, IO} t_dm_owner;
   typedef logic [0:0] t_arb_state;
   localparam t_arb_state CORE_PRI = 1'b0;
   localparam t_arb_state IO_FORCE = 1'b1;
   typedef struct packed {
      t_opcode     opcode;
      logic [31:0] address;
      logic [31:0] data;
   } t_io_req;
endpackage

// File: rtl/d_mem_arb_if.sv
// d_mem_arb_if: core port, IO request/response port and d_mem port of the arbiter.
interface d_mem_arb_if;
   import ss_rvc_pkg::*;
   logic [31:0] AddressDmQ103H;
   logic [31:0] WrDataDmQ103H;
   logic        RdEnDmQ103H;
   logic        WrEnDmQ103H;
   logic        StallDmQ103H;
   logic [31:0] RdDataDmQ104H;
   logic        ReqValidQ501H;
   t_opcode     ReqOpcodeQ501H;
   logic [31:0] ReqAddressQ501H;
   logic [31:0] ReqDataQ501H;
   logic        ReqReadyQ501H;
   logic        RspValidQ502H;
   t_opcode     RspOpcodeQ502H;
   logic [31:0] RspAddressQ502H;
   logic [31:0] RspDataQ502H;
   logic [31:0] MemAddressQ103H;
   logic [31:0] MemWrDataQ103H;
   logic        MemRdEnQ103H;
   logic        MemWrEnQ103H;
   logic [31:0] MemRdDataQ104H;
   modport slave (
      input  AddressDmQ103H, WrDataDmQ103H, RdEnDmQ103H, WrEnDmQ103H,
      input  ReqValidQ501H, ReqOpcodeQ501H, ReqAddressQ501H, ReqDataQ501H,
      input  MemRdDataQ104H,
      output StallDmQ103H, RdDataDmQ104H, ReqReadyQ501H,
      output RspValidQ502H, RspOpcodeQ502H, RspAddressQ502H, RspDataQ502H,
      output MemAddressQ103H, MemWrDataQ103H, MemRdEnQ103H, MemWrEnQ103H
   );
   modport master (
      output AddressDmQ103H, WrDataDmQ103H, RdEnDmQ103H, WrEnDmQ103H,
      output ReqValidQ501H, ReqOpcodeQ501H, ReqAddressQ501H, ReqDataQ501H,
      output MemRdDataQ104H,
      input  StallDmQ103H, RdDataDmQ104H, ReqReadyQ501H,
      input  RspValidQ502H, RspOpcodeQ502H, RspAddressQ502H, RspDataQ502H,
      input  MemAddressQ103H, MemWrDataQ103H, MemRdEnQ103H, MemWrEnQ103H
   );
endinterface

// File: rtl/d_mem_arb_fifo.sv
// d_mem_arb_fifo: IO request buffer; a push is refused while full even if a pop happens the same cycle.
module d_mem_arb_fifo
   import ss_rvc_pkg::*;
#(
   parameter int IO_FIFO_DEPTH = 4
) (
   input  logic    QClk,
   input  logic    RstQnnnH,
   input  logic    push,
   input  logic    pop,
   input  t_io_req pushData,
   output logic    full,
   output logic    empty,
   output t_io_req head
);
   localparam int PW = $clog2(IO_FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT = IO_FIFO_DEPTH[PW:0];
   t_io_req mem [IO_FIFO_DEPTH];
   logic [PW-1:0] rdPtr, wrPtr;
   logic [PW:0] cnt;
   logic doPush, doPop;
   always_comb begin
      full = cnt == FULL_CNT;
      empty = cnt == '0;
      doPush = push && !full;
      doPop = pop && !empty;
      head = mem[rdPtr];
   end
   always_ff @(posedge QClk) if (doPush) mem[wrPtr] <= pushData;
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         rdPtr <= '0;
         wrPtr <= '0;
         cnt <= '0;
      end else begin
         wrPtr <= wrPtr + {{(PW-1){1'b0}}, doPush};
         rdPtr <= rdPtr + {{(PW-1){1'b0}}, doPop};
         cnt <= cnt + {{PW{1'b0}}, doPush} - {{PW{1'b0}}, doPop};
      end
   end
endmodule

// File: rtl/d_mem_arb.sv
// d_mem_arb: core/IO arbiter for the single-port d_mem; core priority, forced IO grant after MAX_WAIT.
// Define D_MEM_ARB_STATS_EN to add saturating core/IO/force grant counters.
module d_mem_arb
   import ss_rvc_pkg::*;
#(
   parameter int IO_FIFO_DEPTH = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic        QClk,
   input  logic        RstQnnnH,
`ifdef D_MEM_ARB_STATS_EN
   output logic [31:0] StatCoreGntCnt,
   output logic [31:0] StatIoGntCnt,
   output logic [31:0] StatForceCnt,
`endif
   d_mem_arb_if.slave  bus
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
   t_arb_state state, stateNext;
   t_dm_owner owner;
   t_io_req fifoHead, ioIn, ioReq;
   logic [WW-1:0] waitCnt, waitNext;
   logic fifoFull, fifoEmpty, coreReq, coreRd, coreGnt, ioGnt, coreRdQ;
   logic [31:0] rdDataQ;
   d_mem_arb_fifo #(.IO_FIFO_DEPTH(IO_FIFO_DEPTH)) fifo (
      .QClk, .RstQnnnH, .push(bus.ReqValidQ501H), .pop(ioGnt), .pushData(ioIn),
      .full(fifoFull), .empty(fifoEmpty), .head(fifoHead)
   );
   always_comb begin
      ioIn = '{opcode: bus.ReqOpcodeQ501H, address: bus.ReqAddressQ501H, data: bus.ReqDataQ501H};
      coreReq = bus.RdEnDmQ103H || bus.WrEnDmQ103H;
      coreRd = bus.RdEnDmQ103H && !bus.WrEnDmQ103H;
      coreGnt = coreReq && state == CORE_PRI;
      ioGnt = !fifoEmpty && (state == IO_FORCE || !coreReq);
      waitNext = (fifoEmpty || ioGnt) ? '0 : (waitCnt == WAIT_MAX ? waitCnt : waitCnt + 1'b1);
      stateNext = (state == CORE_PRI && waitNext == WAIT_MAX) ? IO_FORCE : CORE_PRI;
      bus.StallDmQ103H = coreReq && state == IO_FORCE;
      bus.ReqReadyQ501H = !fifoFull;
      bus.MemAddressQ103H = ioGnt ? fifoHead.address : coreGnt ? bus.AddressDmQ103H : '0;
      bus.MemWrDataQ103H = ioGnt ? fifoHead.data : coreGnt ? bus.WrDataDmQ103H : '0;
      bus.MemRdEnQ103H = ioGnt ? fifoHead.opcode == RD : coreGnt && coreRd;
      bus.MemWrEnQ103H = ioGnt ? fifoHead.opcode == WR : coreGnt && bus.WrEnDmQ103H;
      bus.RdDataDmQ104H = (owner == CORE && coreRdQ) ? bus.MemRdDataQ104H : rdDataQ;
      bus.RspValidQ502H = owner == IO;
      bus.RspOpcodeQ502H = ioReq.opcode;
      bus.RspAddressQ502H = ioReq.address;
      bus.RspDataQ502H = owner != IO ? '0 : ioReq.opcode == RD ? bus.MemRdDataQ104H : ioReq.data;
   end
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         state <= CORE_PRI;
         waitCnt <= '0;
         owner <= NONE;
         coreRdQ <= 1'b0;
         ioReq <= '0;
         rdDataQ <= '0;
      end else begin
         state <= stateNext;
         waitCnt <= waitNext;
         owner <= ioGnt ? IO : coreGnt ? CORE : NONE;
         coreRdQ <= coreGnt && coreRd;
         ioReq <= ioGnt ? fifoHead : ioReq;
         rdDataQ <= bus.RdDataDmQ104H;
      end
   end
`ifdef D_MEM_ARB_STATS_EN
   always_ff @(posedge QClk) begin
      if (RstQnnnH) begin
         StatCoreGntCnt <= '0;
         StatIoGntCnt <= '0;
         StatForceCnt <= '0;
      end else begin
         StatCoreGntCnt <= StatCoreGntCnt + {31'd0, coreGnt && !(&StatCoreGntCnt)};
         StatIoGntCnt <= StatIoGntCnt + {31'd0, ioGnt && !(&StatIoGntCnt)};
         StatForceCnt <= StatForceCnt + {31'd0, ioGnt && state == IO_FORCE && !(&StatForceCnt)};
      end
   end
`endif
   // Simultaneous read and write from the core is illegal; the datapath treats it as a write.
   assert property (@(posedge QClk) disable iff (RstQnnnH) !(bus.RdEnDmQ103H && bus.WrEnDmQ103H));
endmodule

// File: tb/tb_d_mem_arb.sv
// tb_d_mem_arb: directed checks of d_mem_arb against a behavioural d_mem with 1-cycle read latency.
module tb_d_mem_arb;
   import ss_rvc_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   d_mem_arb_if bus();
`ifdef D_MEM_ARB_STATS_EN
   logic [31:0] statCore, statIo, statForce;
`endif
   d_mem_arb #(.IO_FIFO_DEPTH(4), .MAX_WAIT(8)) dut (
      .QClk(clk),
      .RstQnnnH(rst),
`ifdef D_MEM_ARB_STATS_EN
      .StatCoreGntCnt(statCore),
      .StatIoGntCnt(statIo),
      .StatForceCnt(statForce),
`endif
      .bus(bus)
   );
   always #5 clk = ~clk;
   logic [31:0] wmem [logic [31:0]];
   // Unwritten locations read as address ^ 0xA5A50000.
   function automatic logic [31:0] memVal(input logic [31:0] a);
      return wmem.exists(a) ? wmem[a] : a ^ 32'hA5A5_0000;
   endfunction
   always @(posedge clk) begin
      if (bus.MemWrEnQ103H) wmem[bus.MemAddressQ103H] = bus.MemWrDataQ103H;
      if (bus.MemRdEnQ103H) bus.MemRdDataQ104H <= memVal(bus.MemAddressQ103H);
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.RdEnDmQ103H = 1'b0;
      bus.WrEnDmQ103H = 1'b0;
      bus.AddressDmQ103H = '0;
      bus.WrDataDmQ103H = '0;
      bus.ReqValidQ501H = 1'b0;
      bus.ReqOpcodeQ501H = RD;
      bus.ReqAddressQ501H = '0;
      bus.ReqDataQ501H = '0;
   endtask
   task automatic doReset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask
   initial begin
      logic [31:0] lastAcc;
      int idx, pushed, got;
      bus.MemRdDataQ104H = '0;
      doReset();
      @(negedge clk);
      chk("rstStall", bus.StallDmQ103H, 0);
      chk("rstReady", bus.ReqReadyQ501H, 1);
      chk("rstRspValid", bus.RspValidQ502H, 0);
      chk("rstMemRdEn", bus.MemRdEnQ103H, 0);
      chk("rstMemWrEn", bus.MemWrEnQ103H, 0);
      chk("rstRdData", bus.RdDataDmQ104H, 0);
      chk("rstRspData", bus.RspDataQ502H, 0);
      // core read with the FIFO empty
      step();
      bus.RdEnDmQ103H = 1'b1;
      bus.AddressDmQ103H = 32'h1000;
      @(negedge clk);
      chk("t1MemRdEn", bus.MemRdEnQ103H, 1);
      chk("t1MemAddr", bus.MemAddressQ103H, 32'h1000);
      chk("t1Stall", bus.StallDmQ103H, 0);
      step();
      idle();
      @(negedge clk);
      chk("t1RdData", bus.RdDataDmQ104H, 32'hA5A5_1000);
      step();
      @(negedge clk);
      chk("t1Hold", bus.RdDataDmQ104H, 32'hA5A5_1000);
      // IO write with the core idle
      step();
      bus.ReqValidQ501H = 1'b1;
      bus.ReqOpcodeQ501H = WR;
      bus.ReqAddressQ501H = 32'h2000;
      bus.ReqDataQ501H = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t2Ready", bus.ReqReadyQ501H, 1);
      chk("t2NoEarlyWr", bus.MemWrEnQ103H, 0);
      step();
      idle();
      @(negedge clk);
      chk("t2MemWrEn", bus.MemWrEnQ103H, 1);
      chk("t2MemAddr", bus.MemAddressQ103H, 32'h2000);
      chk("t2MemWrData", bus.MemWrDataQ103H, 32'hDEAD_BEEF);
      chk("t2NoEarlyRsp", bus.RspValidQ502H, 0);
      step();
      @(negedge clk);
      chk("t2RspValid", bus.RspValidQ502H, 1);
      chk("t2RspOpcode", bus.RspOpcodeQ502H, WR);
      chk("t2RspAddr", bus.RspAddressQ502H, 32'h2000);
      chk("t2RspData", bus.RspDataQ502H, 32'hDEAD_BEEF);
      step();
      @(negedge clk);
      chk("t2RspPulse", bus.RspValidQ502H, 0);
      step();
      bus.RdEnDmQ103H = 1'b1;
      bus.AddressDmQ103H = 32'h2000;
      step();
      idle();
      @(negedge clk);
      chk("t2ReadBack", bus.RdDataDmQ104H, 32'hDEAD_BEEF);
      // starvation: core reads every cycle, one IO read queued at k=0
      doReset();
      idx = 0;
      lastAcc = '0;
      for (int k = 0; k < 12; k++) begin
         bus.RdEnDmQ103H = 1'b1;
         bus.AddressDmQ103H = 32'h3000 + 4 * idx;
         bus.ReqValidQ501H = k == 0;
         bus.ReqOpcodeQ501H = RD;
         bus.ReqAddressQ501H = 32'h4000;
         @(negedge clk);
         chk("t3Stall", bus.StallDmQ103H, k == 9);
         chk("t3MemAddr", bus.MemAddressQ103H, k == 9 ? 32'h4000 : 32'h3000 + 4 * idx);
         chk("t3RspValid", bus.RspValidQ502H, k == 10);
         if (k == 10) chk("t3RspData", bus.RspDataQ502H, 32'hA5A5_4000);
         if (k > 0) chk("t3RdData", bus.RdDataDmQ104H, memVal(lastAcc));
         if (k != 9) begin
            lastAcc = 32'h3000 + 4 * idx;
            idx++;
         end
         step();
      end
      idle();
      @(negedge clk);
      chk("t3StallIdle", bus.StallDmQ103H, 0);
`ifdef D_MEM_ARB_STATS_EN
      chk("t6Core", statCore, 11);
      chk("t6Io", statIo, 1);
      chk("t6Force", statForce, 1);
`endif
      // five IO reads back-to-back behind a busy core
      doReset();
      pushed = 0;
      got = 0;
      for (int j = 0; j < 60; j++) begin
         bus.RdEnDmQ103H = j < 11;
         bus.AddressDmQ103H = 32'h5000;
         bus.ReqValidQ501H = pushed < 5;
         bus.ReqOpcodeQ501H = RD;
         bus.ReqAddressQ501H = 32'h6000 + 4 * pushed;
         @(negedge clk);
         if (j <= 11) chk("t4Ready", bus.ReqReadyQ501H, j < 4 || j == 10);
         if (j == 9) chk("t4Held", pushed, 4);
         if (bus.RspValidQ502H) begin
            chk("t4RspAddr", bus.RspAddressQ502H, 32'h6000 + 4 * got);
            chk("t4RspData", bus.RspDataQ502H, (32'h6000 + 4 * got) ^ 32'hA5A5_0000);
            got++;
         end
         if (bus.ReqValidQ501H && bus.ReqReadyQ501H) pushed++;
         step();
      end
      chk("t4RspCount", got, 5);
      // reset lands on the grant cycle of a queued IO read
      idle();
      bus.ReqValidQ501H = 1'b1;
      bus.ReqAddressQ501H = 32'h7000;
      @(negedge clk);
      step();
      bus.ReqValidQ501H = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("t5Grant", bus.MemRdEnQ103H, 1);
      step();
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("t5NoRsp", bus.RspValidQ502H, 0);
         chk("t5Ready", bus.ReqReadyQ501H, 1);
         chk("t5NoGrant", bus.MemRdEnQ103H, 0);
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
